// File: rtl/pipe_skid.sv
// ---------------------------------------------------------------------------
// pipe_skid
//
// Two-entry ready/valid skid buffer. Both the forward path (out_valid /
// out_data) and the backward path (in_ready) come straight from flops, so
// no combinational path runs from any input to any output. This breaks long
// ready chains and hands the downstream retiming stage a clean,
// full-cycle-registered data bus.
//
// The payload is opaque. Beats leave in strict FIFO order. The buffer holds
// at most two beats:
//   main register : drives out_data
//   skid register : catches the beat that arrives while main is stalled
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   nreset    in   asynchronous active-low reset
//   flush     in   synchronous clear of all buffered entries
//   in_valid  in   upstream beat valid
//   in_data   in   upstream payload [DW-1:0]
//   in_ready  out  registered; buffer can accept a beat this cycle
//   out_valid out  registered; out_data holds a valid beat
//   out_data  out  registered payload from the main register [DW-1:0]
//   out_ready in   downstream accepts the beat this cycle
//   count     out  occupancy: 0, 1 or 2 (same as the state encoding)
// ---------------------------------------------------------------------------
module pipe_skid #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    count
);

  // The state encoding equals the occupancy, so count is simply the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, out_valid_q;
  logic          accept, consume;

  // Handshakes are judged only against the registered ready and valid.
  // This keeps both handshakes free of any input-to-output path.
  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // Next-state and data-steering logic. Flush overrides every transition.
  // Flush clears only the occupancy. The data registers keep their old
  // contents, because those contents are never visible while out_valid is low.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low in FULL, so only a consume can happen here.
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and data registers. The handshake outputs are decoded from the
  // next state and stored in their own flops. This way they are ready at
  // the start of the cycle instead of being decoded from state_q after
  // the clock edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid
//
// Self-checking bench for pipe_skid with DW=32. Inputs are driven on the
// falling edge. Outputs are sampled 1 time unit after the rising edge.
// A table of directed vectors covers the basic transitions. Hand-written
// sequences use a queue reference model of the buffer. A randomized
// valid/ready run streams numbered beats and checks in-order, lossless
// delivery.
// ---------------------------------------------------------------------------
module tb_pipe_skid;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          nreset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    count;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: the buffered beats, oldest first.
  logic [DW-1:0] modelQ[$];

  // In-order delivery tracking for the randomized run.
  bit            seqCheck = 1'b0;
  logic [DW-1:0] rxNext   = '0;

  typedef struct {
    logic          flush;
    logic          inValid;
    logic [DW-1:0] inData;
    logic          outReady;
    logic          expValid;
    logic [DW-1:0] expData;
    logic          expReady;
    logic [1:0]    expCount;
  } vec_t;

  vec_t vecs[14];

  pipe_skid #(.DW(DW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Compares one value against its expected value and records the result.
  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and waits until just
  // after the next rising edge.
  task automatic applyStimulus(input logic f, input logic v,
                               input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Runs one cycle against the queue model. The model predicts the
  // handshakes from its own occupancy, then updates, then checks all
  // outputs.
  task automatic stepModel(input logic f, input logic v,
                           input logic [DW-1:0] d, input logic r,
                           output bit accepted);
    bit acc, con;
    @(negedge clk);
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    acc = v && (modelQ.size() < 2);
    con = r && (modelQ.size() > 0);
    if (con && seqCheck) begin
      checkOutput("deliveredOrder", out_data, rxNext);
      rxNext++;
    end
    @(posedge clk);
    #1;
    if (con) void'(modelQ.pop_front());
    if (f) modelQ.delete();
    else if (acc) modelQ.push_back(d);
    accepted = acc;
    checkOutput("count", DW'(count), DW'(modelQ.size()));
    checkOutput("inReady", DW'(in_ready), DW'(modelQ.size() < 2));
    checkOutput("outValid", DW'(out_valid), DW'(modelQ.size() > 0));
    if (modelQ.size() > 0) checkOutput("outData", out_data, modelQ[0]);
  endtask

  initial begin
    bit acc;
    logic          pendValid;
    logic [DW-1:0] txNext;
    int            cyc;

    // Directed vectors, applied in order starting from reset. The payload
    // registers keep stale data whenever the buffer goes empty.
    vecs[0]  = '{1'b0, 1'b1, 32'h5, 1'b1, 1'b1, 32'h5, 1'b1, 2'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5, 1'b1, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 32'h5, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 32'h5, 1'b0, 2'd2};
    vecs[4]  = '{1'b0, 1'b1, 32'hB, 1'b1, 1'b1, 32'hA, 1'b1, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 32'hB, 1'b1, 1'b1, 32'hB, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hB, 1'b1, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hB, 1'b1, 2'd0};
    vecs[8]  = '{1'b1, 1'b1, 32'h7, 1'b0, 1'b0, 32'hB, 1'b1, 2'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 32'hC, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 1'b1, 32'hD, 1'b0, 1'b1, 32'hC, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hC, 1'b1, 2'd0};
    vecs[12] = '{1'b0, 1'b1, 32'h9, 1'b1, 1'b1, 32'h9, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h9, 1'b1, 2'd0};

    // Reset and check the reset values.
    nreset    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("resetOutValid", DW'(out_valid), '0);
    checkOutput("resetInReady", DW'(in_ready), 32'd1);
    checkOutput("resetCount", DW'(count), '0);
    checkOutput("resetOutData", out_data, '0);
    @(negedge clk);
    nreset = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].flush, vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
      checkOutput($sformatf("vec%0d.outValid", i), DW'(out_valid), DW'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.outData", i), out_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d.inReady", i), DW'(in_ready), DW'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d.count", i), DW'(count), DW'(vecs[i].expCount));
    end

    // Stream 1..8 back-to-back with downstream always ready.
    for (int i = 1; i <= 8; i++) stepModel(1'b0, 1'b1, DW'(i), 1'b1, acc);
    stepModel(1'b0, 1'b0, '0, 1'b1, acc);

    // Stall the output while A and B arrive, hold C upstream, then release.
    stepModel(1'b0, 1'b1, 32'hA, 1'b0, acc);
    stepModel(1'b0, 1'b1, 32'hB, 1'b0, acc);
    stepModel(1'b0, 1'b1, 32'hC, 1'b0, acc);
    checkOutput("stallCCountFull", DW'(count), 32'd2);
    for (int i = 0; i < 4; i++) stepModel(1'b0, !acc || i == 0, 32'hC, 1'b1, acc);

    // Fill with 3/4, then flush. The next input 9 must be the first output.
    stepModel(1'b0, 1'b1, 32'h3, 1'b0, acc);
    stepModel(1'b0, 1'b1, 32'h4, 1'b0, acc);
    stepModel(1'b1, 1'b0, '0, 1'b0, acc);
    stepModel(1'b0, 1'b1, 32'h9, 1'b0, acc);
    checkOutput("flushFirstOut", out_data, 32'h9);
    stepModel(1'b0, 1'b0, '0, 1'b1, acc);

    // Asynchronous reset while FULL: outputs clear before any clock edge.
    stepModel(1'b0, 1'b1, 32'h3, 1'b0, acc);
    stepModel(1'b0, 1'b1, 32'h4, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    checkOutput("asyncRstOutValid", DW'(out_valid), '0);
    checkOutput("asyncRstCount", DW'(count), '0);
    checkOutput("asyncRstOutData", out_data, '0);
    modelQ.delete();
    @(negedge clk);
    nreset = 1'b1;
    #1;
    checkOutput("asyncRstInReady", DW'(in_ready), 32'd1);

    // Randomized valid/ready with numbered beats. in_valid stays up until
    // the beat is accepted.
    seqCheck  = 1'b1;
    rxNext    = '0;
    txNext    = '0;
    pendValid = 1'b0;
    cyc       = 0;
    while (rxNext < 10000 && cyc < 60000) begin
      if (!pendValid && txNext < 10000) pendValid = ($urandom_range(0, 3) != 0);
      stepModel(1'b0, pendValid, txNext, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        txNext++;
        pendValid = 1'b0;
      end
      cyc++;
    end
    checkOutput("randomAllDelivered", rxNext, 32'd10000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
